// File: rtl/fpu_defs.sv
// Shared FPU definitions: operation codes, exception flag indices and
// the result-queue entry layout used by the writeback stage.
package fpu_defs;

   localparam logic [4:0] OpFeq     = 5'b01010;
   localparam logic [4:0] OpFlt     = 5'b01011;
   localparam logic [4:0] OpFle     = 5'b01100;
   localparam logic [4:0] OpFcvtWS  = 5'b10010;
   localparam logic [4:0] OpFcvtWuS = 5'b10011;
   localparam logic [4:0] OpFclass  = 5'b10100;

   localparam int unsigned FlagNv = 4;
   localparam int unsigned FlagDz = 3;
   localparam int unsigned FlagOf = 2;
   localparam int unsigned FlagUf = 1;
   localparam int unsigned FlagNx = 0;

   typedef struct packed {
      logic [31:0] result;
      logic [4:0]  rd;
      logic        to_int;
      logic [4:0]  exc;
   } result_entry_t;

   // Operations whose result lands in the integer register file.
   function automatic logic is_to_int(input logic [4:0] op);
      return op inside {OpFeq, OpFlt, OpFle, OpFcvtWS, OpFcvtWuS, OpFclass};
   endfunction

endpackage

// File: rtl/fpu_result_fifo.sv
// In-order result queue: storage, wrapping read/write pointers and occupancy
// count. Flush clears pointers and count and drops any same-cycle push/pop.
module fpu_result_fifo
   import fpu_defs::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CntW  = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            push,
   input  logic            pop,
   input  result_entry_t   wdata,
   output result_entry_t   rdata,
   output logic [CntW-1:0] count
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

   result_entry_t   mem_q [DEPTH];
   logic [PtrW-1:0] wptr_q, wptr_d;
   logic [PtrW-1:0] rptr_q, rptr_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
      return (p == LastPtr) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (flush) begin
         wptr_d = '0;
         rptr_d = '0;
         cnt_d  = '0;
      end else begin
         if (push) wptr_d = next_ptr(wptr_q);
         if (pop)  rptr_d = next_ptr(rptr_q);
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // Storage is not reset; only valid entries are ever observed.
   always_ff @(posedge clk) begin
      if (rst_n && push && !flush) begin
         mem_q[wptr_q] <= wdata;
      end
   end

   assign rdata = mem_q[rptr_q];
   assign count = cnt_q;

endmodule

// File: rtl/fpu_result_stage.sv
// FPU writeback stage: queues results, routes them to the FP or integer
// register file and accrues exception flags into FFLAGS at commit.
module fpu_result_stage
   import fpu_defs::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        IN_VALID,
   output logic        IN_READY,
   input  logic [31:0] IN_RESULT,
   input  logic [4:0]  IN_SELECT,
   input  logic [4:0]  IN_RD,
   input  logic [4:0]  IN_EXC,
   input  logic        FLUSH,
   output logic        OUT_VALID,
   input  logic        OUT_READY,
   output logic [31:0] OUT_RESULT,
   output logic [4:0]  OUT_RD,
   output logic        OUT_TO_INT,
   output logic        OUT_FP_WE,
   output logic [4:0]  FFLAGS,
   input  logic        CSR_WE,
   input  logic [4:0]  CSR_WDATA
);

   localparam int unsigned CntW = $clog2(DEPTH + 1);

   result_entry_t   in_entry;
   result_entry_t   head;
   logic [CntW-1:0] count;
   logic            push;
   logic            pop;
   logic [4:0]      fflags_q, fflags_d;

   always_comb begin
      in_entry.result = IN_RESULT;
      in_entry.rd     = IN_RD;
      in_entry.to_int = is_to_int(IN_SELECT);
      in_entry.exc    = IN_EXC;
   end

   // Ready depends only on registered occupancy, never on OUT_READY.
   assign IN_READY  = (count < CntW'(DEPTH));
   assign OUT_VALID = (count != '0);
   assign push      = IN_VALID & IN_READY;
   assign pop       = OUT_VALID & OUT_READY;

   fpu_result_fifo #(
      .DEPTH (DEPTH),
      .CntW  (CntW)
   ) u_fifo (
      .clk   (CLK),
      .rst_n (RESET),
      .flush (FLUSH),
      .push  (push),
      .pop   (pop),
      .wdata (in_entry),
      .rdata (head),
      .count (count)
   );

   assign OUT_RESULT = OUT_VALID ? head.result : '0;
   assign OUT_RD     = OUT_VALID ? head.rd : '0;
   assign OUT_TO_INT = OUT_VALID & head.to_int;
   assign OUT_FP_WE  = OUT_VALID & ~head.to_int & ~FLUSH;

   // CSR write replaces the flags; a committing pop still ORs its exc in.
   always_comb begin
      fflags_d = CSR_WE ? CSR_WDATA : fflags_q;
      if (pop && !FLUSH) begin
         fflags_d = fflags_d | head.exc;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         fflags_q <= '0;
      end else begin
         fflags_q <= fflags_d;
      end
   end

   assign FFLAGS = fflags_q;

endmodule

// File: tb/tb_fpu_result_stage.sv
// Directed bench for fpu_result_stage: table of single-entry push/commit
// vectors plus hand-written full, flush, CSR and reset sequences.
module tb_fpu_result_stage;

   logic        CLK;
   logic        RESET;
   logic        IN_VALID;
   logic        IN_READY;
   logic [31:0] IN_RESULT;
   logic [4:0]  IN_SELECT;
   logic [4:0]  IN_RD;
   logic [4:0]  IN_EXC;
   logic        FLUSH;
   logic        OUT_VALID;
   logic        OUT_READY;
   logic [31:0] OUT_RESULT;
   logic [4:0]  OUT_RD;
   logic        OUT_TO_INT;
   logic        OUT_FP_WE;
   logic [4:0]  FFLAGS;
   logic        CSR_WE;
   logic [4:0]  CSR_WDATA;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [4:0]  sel;
      logic [31:0] res;
      logic [4:0]  rd;
      logic [4:0]  exc;
      logic        to_int;
      logic [4:0]  fflags;
   } vec_t;

   vec_t vecs [10];

   fpu_result_stage #(
      .DEPTH (2)
   ) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .IN_VALID   (IN_VALID),
      .IN_READY   (IN_READY),
      .IN_RESULT  (IN_RESULT),
      .IN_SELECT  (IN_SELECT),
      .IN_RD      (IN_RD),
      .IN_EXC     (IN_EXC),
      .FLUSH      (FLUSH),
      .OUT_VALID  (OUT_VALID),
      .OUT_READY  (OUT_READY),
      .OUT_RESULT (OUT_RESULT),
      .OUT_RD     (OUT_RD),
      .OUT_TO_INT (OUT_TO_INT),
      .OUT_FP_WE  (OUT_FP_WE),
      .FFLAGS     (FFLAGS),
      .CSR_WE     (CSR_WE),
      .CSR_WDATA  (CSR_WDATA)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive_in(input logic v, input logic [4:0] sel, input logic [31:0] res,
                           input logic [4:0] rd, input logic [4:0] exc);
      IN_VALID  = v;
      IN_SELECT = sel;
      IN_RESULT = res;
      IN_RD     = rd;
      IN_EXC    = exc;
   endtask

   task automatic push_one(input logic [4:0] sel, input logic [31:0] res,
                           input logic [4:0] rd, input logic [4:0] exc);
      drive_in(1'b1, sel, res, rd, exc);
      tick();
      IN_VALID = 1'b0;
   endtask

   task automatic csr_write(input logic [4:0] val);
      CSR_WE    = 1'b1;
      CSR_WDATA = val;
      tick();
      CSR_WE    = 1'b0;
   endtask

   initial begin
      vecs[0] = '{5'b00010, 32'h4040_0000, 5'd3,  5'b00001, 1'b0, 5'b00001};
      vecs[1] = '{5'b01011, 32'h0000_0001, 5'd5,  5'b00000, 1'b1, 5'b00001};
      vecs[2] = '{5'b01010, 32'h0000_0000, 5'd7,  5'b10000, 1'b1, 5'b10001};
      vecs[3] = '{5'b01100, 32'h0000_0001, 5'd1,  5'b00000, 1'b1, 5'b10001};
      vecs[4] = '{5'b10010, 32'hFFFF_FFFF, 5'd31, 5'b00001, 1'b1, 5'b10001};
      vecs[5] = '{5'b10011, 32'h0000_0007, 5'd2,  5'b00010, 1'b1, 5'b10011};
      vecs[6] = '{5'b10100, 32'h0000_0200, 5'd4,  5'b00000, 1'b1, 5'b10011};
      vecs[7] = '{5'b01001, 32'h3F80_0000, 5'd9,  5'b00100, 1'b0, 5'b10111};
      vecs[8] = '{5'b01101, 32'h4000_0000, 5'd10, 5'b01000, 1'b0, 5'b11111};
      vecs[9] = '{5'b10101, 32'hC000_0000, 5'd11, 5'b00000, 1'b0, 5'b11111};

      RESET     = 1'b0;
      FLUSH     = 1'b0;
      OUT_READY = 1'b0;
      CSR_WE    = 1'b0;
      CSR_WDATA = '0;
      drive_in(1'b0, '0, '0, '0, '0);
      tick();
      tick();
      check("reset out_valid", 32'(OUT_VALID), 32'd0);
      check("reset in_ready", 32'(IN_READY), 32'd1);
      check("reset fflags", 32'(FFLAGS), 32'd0);
      check("reset fp_we", 32'(OUT_FP_WE), 32'd0);
      check("reset to_int", 32'(OUT_TO_INT), 32'd0);
      check("reset result", OUT_RESULT, 32'd0);
      check("reset rd", 32'(OUT_RD), 32'd0);
      RESET = 1'b1;
      tick();

      // Single-entry push, inspect head, then commit and check accrued flags.
      for (int i = 0; i < 10; i++) begin
         logic [4:0] prev_flags;
         prev_flags = (i == 0) ? 5'b00000 : vecs[i-1].fflags;
         push_one(vecs[i].sel, vecs[i].res, vecs[i].rd, vecs[i].exc);
         check($sformatf("vec%0d out_valid", i), 32'(OUT_VALID), 32'd1);
         check($sformatf("vec%0d result", i), OUT_RESULT, vecs[i].res);
         check($sformatf("vec%0d rd", i), 32'(OUT_RD), 32'(vecs[i].rd));
         check($sformatf("vec%0d to_int", i), 32'(OUT_TO_INT), 32'(vecs[i].to_int));
         check($sformatf("vec%0d fp_we", i), 32'(OUT_FP_WE), 32'(!vecs[i].to_int));
         check($sformatf("vec%0d flags at push", i), 32'(FFLAGS), 32'(prev_flags));
         OUT_READY = 1'b1;
         tick();
         OUT_READY = 1'b0;
         check($sformatf("vec%0d empty after pop", i), 32'(OUT_VALID), 32'd0);
         check($sformatf("vec%0d result zero", i), OUT_RESULT, 32'd0);
         check($sformatf("vec%0d flags at commit", i), 32'(FFLAGS), 32'(vecs[i].fflags));
      end

      csr_write(5'b00000);
      check("csr clear", 32'(FFLAGS), 32'd0);

      // Fill to DEPTH=2, third push refused, then pop while full admits nothing.
      push_one(5'b00010, 32'h11, 5'd1, 5'b0);
      check("full: ready after 1", 32'(IN_READY), 32'd1);
      push_one(5'b00010, 32'h22, 5'd2, 5'b0);
      check("full: ready after 2", 32'(IN_READY), 32'd0);
      push_one(5'b00010, 32'h33, 5'd3, 5'b0);
      check("full: ready after 3", 32'(IN_READY), 32'd0);
      check("full: head kept", OUT_RESULT, 32'h11);
      drive_in(1'b1, 5'b00010, 32'h33, 5'd3, 5'b0);
      OUT_READY = 1'b1;
      tick();
      IN_VALID  = 1'b0;
      OUT_READY = 1'b0;
      check("full pop+push: ready", 32'(IN_READY), 32'd1);
      check("full pop+push: head", OUT_RESULT, 32'h22);
      OUT_READY = 1'b1;
      tick();
      OUT_READY = 1'b0;
      check("full pop+push: third dropped", 32'(OUT_VALID), 32'd0);

      // Partial push+pop holds count; exercises pointer wrap.
      push_one(5'b00010, 32'h44, 5'd4, 5'b0);
      drive_in(1'b1, 5'b00010, 32'h55, 5'd5, 5'b0);
      OUT_READY = 1'b1;
      tick();
      IN_VALID  = 1'b0;
      OUT_READY = 1'b0;
      check("hold: valid", 32'(OUT_VALID), 32'd1);
      check("hold: head", OUT_RESULT, 32'h55);
      check("hold: ready", 32'(IN_READY), 32'd1);
      OUT_READY = 1'b1;
      tick();
      OUT_READY = 1'b0;
      check("hold: drained", 32'(OUT_VALID), 32'd0);

      // Flush with pop pending: no commit, no accrual.
      push_one(5'b00010, 32'h66, 5'd6, 5'b01000);
      push_one(5'b00010, 32'h77, 5'd7, 5'b10000);
      FLUSH     = 1'b1;
      OUT_READY = 1'b1;
      #1;
      check("flush: fp_we masked", 32'(OUT_FP_WE), 32'd0);
      tick();
      FLUSH     = 1'b0;
      OUT_READY = 1'b0;
      check("flush: empty", 32'(OUT_VALID), 32'd0);
      check("flush: ready", 32'(IN_READY), 32'd1);
      check("flush: flags", 32'(FFLAGS), 32'd0);

      // Flush drops a same-cycle push but honours CSR write.
      drive_in(1'b1, 5'b00010, 32'h88, 5'd8, 5'b00001);
      FLUSH     = 1'b1;
      CSR_WE    = 1'b1;
      CSR_WDATA = 5'b00110;
      tick();
      IN_VALID = 1'b0;
      FLUSH    = 1'b0;
      CSR_WE   = 1'b0;
      check("flush push dropped", 32'(OUT_VALID), 32'd0);
      check("flush csr kept", 32'(FFLAGS), 32'b00110);

      // CSR write coinciding with a commit.
      csr_write(5'b00011);
      push_one(5'b00010, 32'h99, 5'd9, 5'b00100);
      CSR_WE    = 1'b1;
      CSR_WDATA = 5'b00000;
      OUT_READY = 1'b1;
      tick();
      CSR_WE    = 1'b0;
      OUT_READY = 1'b0;
      check("csr+pop flags", 32'(FFLAGS), 32'b00100);

      // Reset mid-stream overrides everything.
      csr_write(5'b11111);
      push_one(5'b00010, 32'hAA, 5'd1, 5'b0);
      push_one(5'b00010, 32'hBB, 5'd2, 5'b0);
      check("pre-reset full", 32'(IN_READY), 32'd0);
      RESET     = 1'b0;
      OUT_READY = 1'b1;
      CSR_WE    = 1'b1;
      CSR_WDATA = 5'b01010;
      drive_in(1'b1, 5'b00010, 32'hCC, 5'd3, 5'b0);
      tick();
      RESET     = 1'b1;
      OUT_READY = 1'b0;
      CSR_WE    = 1'b0;
      IN_VALID  = 1'b0;
      check("midreset out_valid", 32'(OUT_VALID), 32'd0);
      check("midreset fflags", 32'(FFLAGS), 32'd0);
      check("midreset in_ready", 32'(IN_READY), 32'd1);
      check("midreset result", OUT_RESULT, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/fpu_result_stage.md
FPU_RESULT_STAGE -- requirements
Module: fpu_result_stage

Interface
REQ-001 Parameter DEPTH, default 2, result-queue entries (legal 2..8).
REQ-002 Port: CLK  input  1  single clock, all state updates on rising edge.
REQ-003 Port: RESET  input  1  synchronous, active-low reset.
REQ-004 Port: IN_VALID  input  1  FPU result presented.
REQ-005 Port: IN_READY  output  1  stage can accept an entry.
REQ-006 Port: IN_RESULT  input  32  FPU RESULT bus.
REQ-007 Port: IN_SELECT  input  5  FPU operation code that produced IN_RESULT.
REQ-008 Port: IN_RD  input  5  destination register index.
REQ-009 Port: IN_EXC  input  5  exception flags {NV,DZ,OF,UF,NX}, bit4=NV.
REQ-010 Port: FLUSH  input  1  discard all queued and incoming entries.
REQ-011 Port: OUT_VALID  output  1  head entry available.
REQ-012 Port: OUT_READY  input  1  writeback consumer accepts head.
REQ-013 Port: OUT_RESULT  output  32  head result.
REQ-014 Port: OUT_RD  output  5  head destination index.
REQ-015 Port: OUT_TO_INT  output  1  head targets integer register file.
REQ-016 Port: OUT_FP_WE  output  1  FP register-file write enable.
REQ-017 Port: FFLAGS  output  5  sticky accrued exception flags.
REQ-018 Port: CSR_WE  input  1  software write of FFLAGS.
REQ-019 Port: CSR_WDATA  input  5  value for FFLAGS write.

Function
REQ-020 The stage SHALL be a DEPTH-entry in-order queue of {result, rd, to_int, exc}; push = IN_VALID & IN_READY, pop = OUT_VALID & OUT_READY.
REQ-021 IN_READY SHALL be 1 iff count < DEPTH, derived from registered count only (no combinational path from OUT_READY); when full, no push even if a pop occurs in that cycle.
REQ-022 Occupancy states: EMPTY (count=0), PARTIAL, FULL (count=DEPTH); push-only +1, pop-only -1, push+pop holds count.
REQ-023 Latency: an entry pushed on edge N SHALL appear on OUT_* after edge N (visible cycle N+1); no same-cycle bypass.
REQ-024 OUT_VALID = (count != 0); OUT_RESULT/OUT_RD/OUT_TO_INT SHALL reflect the head entry, 0 when EMPTY.
REQ-025 to_int SHALL be 1 for IN_SELECT in {01010 FEQ, 01011 FLT, 01100 FLE, 10010 FCVT.W.S, 10011 FCVT.WU.S, 10100 FCLASS}, else 0.
REQ-026 OUT_FP_WE = OUT_VALID & ~OUT_TO_INT & ~FLUSH.
REQ-027 On pop (not under FLUSH), FFLAGS SHALL OR in the popped entry's exc bits; flags accrue at commit, never at push.
REQ-028 CSR_WE SHALL load FFLAGS with CSR_WDATA; with a simultaneous pop, FFLAGS <= CSR_WDATA | popped exc.
REQ-029 FLUSH SHALL, at the next edge, set count=0 and pointers to 0, drop any same-cycle push, and suppress commit of a same-cycle pop (no flag accrual); a same-cycle CSR_WE still takes effect.
REQ-030 Read/write pointers SHALL wrap modulo DEPTH.

Reset
REQ-031 With RESET=0 at an edge: count=0, pointers=0, FFLAGS=0, OUT_VALID=0, OUT_FP_WE=0, OUT_TO_INT=0, OUT_RESULT=0, OUT_RD=0, IN_READY=1 after the edge.
REQ-032 Reset SHALL override FLUSH, CSR_WE and push/pop in the same cycle; queue contents need not be cleared.

Structure
REQ-033 FPU operation-code constants (5-bit SELECT values) and flag bit indices SHALL reside in a shared fpu_defs package/header used by the FPU and this stage.
REQ-034 Queue storage and pointers SHALL be one sub-module, fpu_result_fifo; classification and FFLAGS logic stay at top level.

Verification
REQ-035 Reset then push FMUL result 0x40400000, rd=3, exc=00001, OUT_READY=1 -> next cycle OUT_VALID=1, OUT_FP_WE=1, OUT_RD=3; after pop FFLAGS=00001.
REQ-036 OUT_READY=0, push 3 entries with DEPTH=2 -> IN_READY=0 after 2nd push, 3rd not accepted; then pop/push in the same cycle while full -> count drops to 1, no push.
REQ-037 Push FLT (SELECT=01011) result 0x00000001 -> OUT_TO_INT=1, OUT_FP_WE=0.
REQ-038 Two entries queued with exc 01000 and 10000, FLUSH asserted with OUT_READY=1 -> count=0 next cycle, FFLAGS unchanged (0).
REQ-039 FFLAGS=00011, CSR_WE=1, CSR_WDATA=00000 in the same cycle as a pop with exc=00100 -> FFLAGS=00100.
REQ-040 RESET=0 mid-stream with 2 entries queued and FFLAGS=11111 -> next cycle OUT_VALID=0, FFLAGS=0, IN_READY=1.
